// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the memory stage: instruction codes, status codes
// and the memory-stage FSM state type.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    typedef enum logic [1:0] {
        INS = 2'd0,
        AOK = 2'd1,
        HLT = 2'd2,
        ADR = 2'd3
    } stat_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational decode of an instruction into its data-memory access (direction,
// address, write data) plus the status it would report, including the bounds check.
module mem_access_decode
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        need_access,
    output logic        we,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    output stat_t       pre_stat
);

    // Highest legal start address of an 8-byte access, as a full 64-bit value.
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;

    logic accesses_mem;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        accesses_mem = 1'b0;
        we           = 1'b0;
        addr         = '0;
        wdata        = '0;
        pre_stat     = AOK;
        case (icode)
            RMMOVQ, PUSHQ: begin
                accesses_mem = 1'b1;
                we           = 1'b1;
                addr         = valE;
                wdata        = valA;
            end
            CALL: begin
                accesses_mem = 1'b1;
                we           = 1'b1;
                addr         = valE;
                wdata        = valP;
            end
            MRMOVQ: begin
                accesses_mem = 1'b1;
                addr         = valE;
            end
            POPQ, RET: begin
                accesses_mem = 1'b1;
                addr         = valA;
            end
            HALT:                            pre_stat = HLT;
            NOP, CMOVXX, IRMOVQ, OPQ, JXX:   pre_stat = AOK;
            default:                         pre_stat = INS;
        endcase

        need_access = accesses_mem;
        if (accesses_mem && (addr > MAX_ADDR)) begin
            need_access = 1'b0;
            pre_stat    = ADR;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: issues at most one data-memory access per instruction over a
// req/ack handshake with timeout, then reports valM/stat with a one-cycle out_valid pulse.
module memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    output logic [63:0] valM,
    output logic [1:0]  stat
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       res_valm;
    stat_t             res_stat;

    logic              dec_need;
    logic              dec_we;
    logic [63:0]       dec_addr;
    logic [63:0]       dec_wdata;
    stat_t             dec_stat;

    mem_access_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
        .icode       (icode),
        .valE        (valE),
        .valA        (valA),
        .valP        (valP),
        .need_access (dec_need),
        .we          (dec_we),
        .addr        (dec_addr),
        .wdata       (dec_wdata),
        .pre_stat    (dec_stat)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking to avoid
    // read-after-write races between registers updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            valM      <= '0;
            stat      <= AOK;
            cnt       <= '0;
            res_valm  <= '0;
            res_stat  <= AOK;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        busy     <= 1'b1;
                        res_valm <= '0;
                        res_stat <= dec_stat;
                        if (dec_need) begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= dec_we;
                            mem_addr  <= dec_addr;
                            mem_wdata <= dec_wdata;
                            cnt       <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                // An ack in the final allowed cycle is checked first, so it beats the timeout.
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (mem_err) begin
                            res_valm <= '0;
                            res_stat <= ADR;
                        end else begin
                            res_valm <= mem_we ? 64'd0 : mem_rdata;
                            res_stat <= AOK;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_req  <= 1'b0;
                        res_stat <= ADR;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Results are published only together with out_valid so they hold until the next pulse.
                DONE: begin
                    out_valid <= 1'b1;
                    valM      <= res_valm;
                    stat      <= res_stat;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed and randomized instructions against a
// reference model of the access rules, with a handshake-driving memory responder.
module tb_memory_stage;

    localparam int unsigned MEM_BYTES = 8192;
    localparam int unsigned TIMEOUT   = 16;
    localparam logic [1:0]  S_INS = 2'd0, S_AOK = 2'd1, S_HLT = 2'd2, S_ADR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  icode = '0;
    logic [63:0] valE = '0, valA = '0, valP = '0;
    logic        busy, mem_req, mem_we, out_valid;
    logic [63:0] mem_addr, mem_wdata, valM;
    logic        mem_ack = 1'b0, mem_err = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic [1:0]  stat;

    int compared   = 0;
    int mismatched = 0;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .icode     (icode),
        .valE      (valE),
        .valA      (valA),
        .valP      (valP),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .out_valid (out_valid),
        .valM      (valM),
        .stat      (stat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          access;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  stat;
    } exp_t;

    // Reference: which instructions touch memory, where, and what they report.
    function automatic exp_t model(input logic [3:0] ic, input logic [63:0] e,
                                   input logic [63:0] a, input logic [63:0] p);
        exp_t m;
        m.access = 1'b0; m.we = 1'b0; m.addr = '0; m.wdata = '0; m.stat = S_AOK;
        if (ic inside {4'h4, 4'hA})      begin m.access = 1; m.we = 1; m.addr = e; m.wdata = a; end
        else if (ic == 4'h8)             begin m.access = 1; m.we = 1; m.addr = e; m.wdata = p; end
        else if (ic == 4'h5)             begin m.access = 1; m.addr = e; end
        else if (ic inside {4'h9, 4'hB}) begin m.access = 1; m.addr = a; end
        else if (ic == 4'h0)             m.stat = S_HLT;
        else if (ic > 4'hB)              m.stat = S_INS;
        if (m.access && m.addr > 64'(MEM_BYTES) - 64'd8) begin
            m.access = 0;
            m.stat   = S_ADR;
        end
        return m;
    endfunction

    // ack_k: ack arrives in the k-th cycle of mem_req (0 = never). poke re-strobes in_valid while busy.
    task automatic run_op(input string tag, input logic [3:0] ic, input logic [63:0] e,
                          input logic [63:0] a, input logic [63:0] p, input int ack_k,
                          input bit err, input logic [63:0] rdata, input bit poke);
        exp_t        m;
        bit          acked;
        int          exp_req, n, req_n, ov_n, pulses, unstable;
        logic [63:0] exp_valm, f_addr, f_wdata, ov_valm;
        logic [1:0]  exp_stat, ov_stat;
        logic        f_we;

        m = model(ic, e, a, p);
        acked = (ack_k != 0) && (ack_k <= int'(TIMEOUT));
        if (m.access) begin
            exp_req  = acked ? ack_k : int'(TIMEOUT);
            exp_stat = (acked && !err) ? S_AOK : S_ADR;
            exp_valm = (acked && !err && !m.we) ? rdata : 64'd0;
        end else begin
            exp_req  = 0;
            exp_stat = m.stat;
            exp_valm = 64'd0;
        end

        @(negedge clk);
        in_valid = 1'b1; icode = ic; valE = e; valA = a; valP = p; mem_rdata = rdata;
        n = 0; req_n = 0; ov_n = -1; pulses = 0; unstable = 0;
        f_addr = '0; f_wdata = '0; f_we = 1'b0; ov_valm = '0; ov_stat = '0;
        while (n < 60 && !(ov_n >= 0 && n >= ov_n + 3)) begin
            @(negedge clk);
            n++;
            in_valid = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
            if (poke && n == 1) begin
                in_valid = 1'b1; icode = 4'h5; valE = 64'h0;
            end
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata;
                end else if (mem_addr !== f_addr || mem_we !== f_we || mem_wdata !== f_wdata) begin
                    unstable++;
                end
                if (req_n == ack_k) begin
                    mem_ack = 1'b1; mem_err = err;
                end
            end else if (!m.access && n == 1) begin
                mem_ack = 1'b1; mem_err = 1'b1;
            end
            if (out_valid) begin
                pulses++;
                if (ov_n < 0) begin
                    ov_n = n; ov_valm = valM; ov_stat = stat;
                end
            end
        end
        mem_ack = 1'b0; mem_err = 1'b0;

        check({tag, " req_cycles"}, 64'(req_n), 64'(exp_req));
        if (m.access) begin
            check({tag, " addr"}, f_addr, m.addr);
            check({tag, " we"}, 64'(f_we), 64'(m.we));
            if (m.we) check({tag, " wdata"}, f_wdata, m.wdata);
            check({tag, " req_stable"}, 64'(unstable), 64'd0);
        end
        check({tag, " latency"}, 64'(ov_n), 64'(2 + exp_req));
        check({tag, " pulses"}, 64'(pulses), 64'd1);
        check({tag, " valM"}, ov_valm, exp_valm);
        check({tag, " stat"}, 64'(ov_stat), 64'(exp_stat));
        check({tag, " valM_hold"}, valM, exp_valm);
        check({tag, " stat_hold"}, 64'(stat), 64'(exp_stat));
    endtask

    initial begin
        int pulses;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst mem_req", 64'(mem_req), 64'd0);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst mem_addr", mem_addr, 64'd0);
        check("rst mem_wdata", mem_wdata, 64'd0);
        check("rst valM", valM, 64'd0);
        check("rst stat", 64'(stat), 64'(S_AOK));
        rst_n = 1'b1;

        run_op("rmmovq",   4'h4, 64'h100, 64'hDEAD, 64'h0, 3, 1'b0, 64'h5555, 1'b0);
        run_op("popq",     4'hB, 64'h0, 64'h200, 64'h0, 1, 1'b0, 64'h1234, 1'b0);
        run_op("mrmovq_oob", 4'h5, 64'd8185, 64'h0, 64'h0, 1, 1'b0, 64'h77, 1'b0);
        run_op("call_to",  4'h8, 64'h1F8, 64'h0, 64'h40, 0, 1'b0, 64'h0, 1'b0);
        run_op("halt",     4'h0, 64'h10, 64'h10, 64'h10, 1, 1'b0, 64'h0, 1'b0);
        run_op("ins",      4'hC, 64'h10, 64'h10, 64'h10, 1, 1'b0, 64'h0, 1'b0);
        run_op("opq",      4'h6, 64'h10, 64'h10, 64'h10, 1, 1'b0, 64'h0, 1'b0);
        run_op("mrmovq_edge_ack16", 4'h5, 64'd8184, 64'h0, 64'h0, 16, 1'b0, 64'hCAFE_F00D, 1'b1);
        run_op("pushq_err", 4'hA, 64'h80, 64'h99, 64'h0, 2, 1'b1, 64'h0, 1'b1);
        run_op("mrmovq_err", 4'h5, 64'h88, 64'h0, 64'h0, 4, 1'b1, 64'hABCD, 1'b0);
        run_op("ret_wrap", 4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 1'b0, 64'h1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ric;
            logic [63:0] re, ra, rp;
            int          rk;
            ric = 4'($urandom_range(0, 15));
            re  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(8180, 8200)) : 64'($urandom_range(0, 8191));
            ra  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8191));
            rp  = {$urandom, $urandom};
            rk  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 18);
            run_op("rand", ric, re, ra, rp, rk, ($urandom_range(0, 4) == 0), {$urandom, $urandom},
                   ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of an outstanding access.
        @(negedge clk);
        in_valid = 1'b1; icode = 4'h8; valE = 64'h1F8; valP = 64'h40;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst req_before", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst mem_req", 64'(mem_req), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 64'hBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst late_ack_pulses", 64'(pulses), 64'd0);
        check("midrst mem_req_after", 64'(mem_req), 64'd0);
        check("midrst stat", 64'(stat), 64'(S_AOK));
        check("midrst valM", valM, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
